bypass_scoreboard: RTL

Parametrised operand-forwarding and hazard unit for the pipelined 16-bit CPU. It sits between instruction decode (ID) and the execute/memory/write-back stages. It tracks the destination register of every in-flight instruction in a tag pipeline and selects each ID source operand from the youngest matching stage or the register file. When a load result is not yet available it raises a stall, which makes it the successor to the fixed two-level EX/ME bypass chain.

---
 rtl/bypass_scoreboard.sv | 100 ++++++++++
 1 files changed

// File: rtl/bypass_scoreboard.sv
// Operand forwarding and load-use hazard unit: tracks in-flight destination tags
// and resolves each ID source operand from the youngest matching stage or the RF.
module bypass_scoreboard #(
  parameter int DATA_WIDTH       = 16,
  parameter int REG_ADDR_WIDTH   = 4,
  parameter int NUM_READ_PORTS   = 2,
  parameter int FWD_STAGES       = 2,
  parameter int LOAD_READY_STAGE = 1,
  parameter int STALL_CNT_WIDTH  = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 id_valid,
  input  logic [NUM_READ_PORTS*REG_ADDR_WIDTH-1:0] id_src_addr,
  input  logic [NUM_READ_PORTS-1:0]            id_src_used,
  input  logic [NUM_READ_PORTS*DATA_WIDTH-1:0] id_src_rf_data,
  input  logic                                 id_dst_we,
  input  logic [REG_ADDR_WIDTH-1:0]            id_dst_addr,
  input  logic                                 id_is_load,
  input  logic                                 flush,
  input  logic [FWD_STAGES*DATA_WIDTH-1:0]     stage_result,
  output logic [NUM_READ_PORTS*DATA_WIDTH-1:0] id_src_data,
  output logic                                 stall,
  output logic                                 id_fire,
  output logic [STALL_CNT_WIDTH-1:0]           stall_count
);

  localparam int SEL_W = (FWD_STAGES > 1) ? $clog2(FWD_STAGES) : 1;

  // Handshake: the ID instruction is accepted (id_fire) in a cycle where
  // id_valid=1, stall=0 and flush=0; while stall=1 the producer holds every
  // ID input stable and the unit re-evaluates against the advancing tags.

  logic [FWD_STAGES-1:0]     tagValid;
  logic [FWD_STAGES-1:0]     tagIsLoad;
  logic [REG_ADDR_WIDTH-1:0] tagAddr [FWD_STAGES];

  logic [NUM_READ_PORTS-1:0] hazardVec;
  logic [STALL_CNT_WIDTH-1:0] stallCount;

  for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : gen_port
    logic [REG_ADDR_WIDTH-1:0] srcAddr;
    logic [SEL_W-1:0]          selIdx;
    logic                      selFound;

    assign srcAddr = id_src_addr[p*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];

    // Scan oldest to youngest so the lowest matching stage is the one kept.
    always_comb begin
      selIdx   = '0;
      selFound = 1'b0;
      for (int k = FWD_STAGES - 1; k >= 0; k--) begin
        if (id_src_used[p] && tagValid[k] && (tagAddr[k] == srcAddr)) begin
          selIdx   = SEL_W'(k);
          selFound = 1'b1;
        end
      end
    end

    always_comb begin
      if (selFound) begin
        id_src_data[p*DATA_WIDTH +: DATA_WIDTH] = stage_result[selIdx*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        id_src_data[p*DATA_WIDTH +: DATA_WIDTH] = id_src_rf_data[p*DATA_WIDTH +: DATA_WIDTH];
      end
    end

    assign hazardVec[p] = selFound && tagIsLoad[selIdx] && (int'(selIdx) < LOAD_READY_STAGE);
  end

  assign stall       = id_valid & ~flush & (|hazardVec);
  assign id_fire     = id_valid & ~stall & ~flush;
  assign stall_count = stallCount;

  // Back end never stalls, so tags advance every clock; a stalled or flushed
  // ID slot enters stage 0 as an invalid bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      tagValid   <= '0;
      tagIsLoad  <= '0;
      stallCount <= '0;
      for (int k = 0; k < FWD_STAGES; k++) begin
        tagAddr[k] <= '0;
      end
    end else begin
      tagValid[0]  <= id_fire & id_dst_we;
      tagIsLoad[0] <= id_is_load;
      tagAddr[0]   <= id_dst_addr;
      for (int k = 1; k < FWD_STAGES; k++) begin
        tagValid[k]  <= tagValid[k-1];
        tagIsLoad[k] <= tagIsLoad[k-1];
        tagAddr[k]   <= tagAddr[k-1];
      end
      if (stall && (stallCount != '1)) begin
        stallCount <= stallCount + 1'b1;
      end
    end
  end

endmodule
